// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one bit per clock, LSB first, via a borrow flop.
// Result and flags are published together when the last bit is processed.
module serial_subtractor #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] diff_out,
    output logic             borrow_out,
    output logic             zero_out,
    output logic             neg_out,
    output logic             ovf_out
);

    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   res_q;
    logic               br_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               a_msb_q;
    logic               b_msb_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   diff_q;
    logic               borrow_q;
    logic               zero_q;
    logic               neg_q;
    logic               ovf_q;

    logic               bit_d;
    logic               br_d;
    logic [WIDTH-1:0]   res_d;
    logic               last_run;

    always_comb begin
        bit_d    = a_q[0] ^ b_q[0] ^ br_q;
        br_d     = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
        res_d    = {bit_d, res_q[WIDTH-1:1]};
        last_run = (cnt_q == CNT_W'(WIDTH - 1));
    end

    // Operand MSBs are kept aside because the shift registers lose them.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b1;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start_in) begin
                        a_q     <= a_in;
                        b_q     <= b_in;
                        a_msb_q <= a_in[WIDTH-1];
                        b_msb_q <= b_in[WIDTH-1];
                        br_q    <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    res_q <= res_d;
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    br_q  <= br_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_run) begin
                        diff_q   <= res_d;
                        borrow_q <= br_d;
                        zero_q   <= (res_d == '0);
                        neg_q    <= res_d[WIDTH-1];
                        ovf_q    <= (a_msb_q != b_msb_q) && (res_d[WIDTH-1] != a_msb_q);
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_out   = busy_q;
    assign done_out   = done_q;
    assign diff_out   = diff_q;
    assign borrow_out = borrow_q;
    assign zero_out   = zero_q;
    assign neg_out    = neg_q;
    assign ovf_out    = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: driver pushes expected results,
// a negedge monitor pops them on done_out and checks held outputs otherwise.
module tb_serial_subtractor;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_in = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         busy_out, done_out, borrow_out, zero_out, neg_out, ovf_out;
    logic [W-1:0] diff_out;

    int unsigned  checks = 0;
    int unsigned  errors = 0;
    int unsigned  cyc = 0;

    typedef struct {
        logic [W-1:0] diff;
        logic         borrow;
        logic         zero;
        logic         neg;
        logic         ovf;
        int unsigned  cyc;
    } exp_t;

    exp_t q[$];
    exp_t held;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk_in     (clk),
        .rst_in     (rst),
        .start_in   (start_in),
        .a_in       (a_in),
        .b_in       (b_in),
        .busy_out   (busy_out),
        .done_out   (done_out),
        .diff_out   (diff_out),
        .borrow_out (borrow_out),
        .zero_out   (zero_out),
        .neg_out    (neg_out),
        .ovf_out    (ovf_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t reset_vals();
        exp_t e;
        e.diff = '0; e.borrow = 1'b0; e.zero = 1'b1; e.neg = 1'b0; e.ovf = 1'b0; e.cyc = 0;
        return e;
    endfunction

    // Reference: plain wide arithmetic, signed range test for overflow.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int unsigned c);
        exp_t   e;
        longint sa, sb, sd, maxv, minv;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        sd   = sa - sb;
        maxv = (longint'(1) << (W - 1)) - 1;
        minv = -(longint'(1) << (W - 1));
        e.diff   = a - b;
        e.borrow = (a < b);
        e.zero   = (a == b);
        e.neg    = (sd < 0) ? (sd >= minv) : (sd > maxv);
        e.ovf    = (sd > maxv) || (sd < minv);
        e.cyc    = c + W;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst == 1'b0) begin
            if (done_out) begin
                if (q.size() == 0) begin
                    chk("spurious_done", 64'(done_out), 64'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("diff", 64'(diff_out), 64'(e.diff));
                    chk("flags(borrow,zero,neg,ovf)", 64'({borrow_out, zero_out, neg_out, ovf_out}),
                        64'({e.borrow, e.zero, e.neg, e.ovf}));
                    chk("done_cycle", 64'(cyc), 64'(e.cyc));
                    chk("busy_in_done", 64'(busy_out), 64'd0);
                    held = e;
                end
            end else begin
                chk("hold_diff", 64'(diff_out), 64'(held.diff));
                chk("hold_flags", 64'({borrow_out, zero_out, neg_out, ovf_out}),
                    64'({held.borrow, held.zero, held.neg, held.ovf}));
                chk("busy", 64'(busy_out), 64'(q.size() != 0));
            end
        end
    end

    // Caller must be at a negedge with busy_out low.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        a_in = a;
        b_in = b;
        start_in = 1'b1;
        @(posedge clk);
        #1;
        q.push_back(model(a, b, cyc));
        @(negedge clk);
        start_in = 1'b0;
    endtask

    // Returns at the negedge where done_out is seen; optionally scrambles inputs during RUN.
    task automatic wait_done(input bit perturb);
        int unsigned n;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (done_out) begin
                start_in = 1'b0;
                break;
            end
            if (perturb) begin
                a_in = $urandom;
                b_in = $urandom;
                start_in = ($urandom_range(0, 3) == 0);
            end
            n++;
            if (n > 3 * W) begin
                start_in = 1'b0;
                chk("done_timeout", 64'(done_out), 64'd1);
                break;
            end
        end
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] specials [6];
        specials[0] = '0;
        specials[1] = '1;
        specials[2] = 32'h8000_0000;
        specials[3] = 32'h7FFF_FFFF;
        specials[4] = 32'h0000_0001;
        specials[5] = 32'hFFFF_FFFE;
        if ($urandom_range(0, 2) == 0) return specials[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        logic [W-1:0] ra, rb;
        held = reset_vals();
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({busy_out, done_out, borrow_out, zero_out, neg_out, ovf_out}), 64'b000100);
        chk("reset_diff", 64'(diff_out), 64'd0);
        rst = 1'b0;

        issue(32'd5, 32'd3);                   wait_done(0);
        issue(32'd3, 32'd5);                   wait_done(0);
        issue(32'h8000_0000, 32'd1);           wait_done(0);
        issue(32'hDEAD_BEEF, 32'hDEAD_BEEF);   wait_done(0);

        // Start pulse with new operands mid-run must be ignored.
        issue(32'd100, 32'd1);
        repeat (10) @(negedge clk);
        start_in = 1'b1; a_in = 32'h1234_5678; b_in = 32'h0000_0042;
        @(negedge clk);
        start_in = 1'b0;
        wait_done(0);

        // Back-to-back: accepted in the DONE cycle.
        issue(32'd7, 32'd9);                   wait_done(0);

        // Asynchronous reset mid-run.
        issue(32'hCAFE_0000, 32'h0000_BABE);
        repeat (10) @(negedge clk);
        #2;
        rst = 1'b1;
        q.delete();
        held = reset_vals();
        #1;
        chk("midrun_reset_outputs", 64'({busy_out, done_out, borrow_out, zero_out, neg_out, ovf_out}), 64'b000100);
        chk("midrun_reset_diff", 64'(diff_out), 64'd0);
        @(negedge clk);
        chk("reset_no_done", 64'(done_out), 64'd0);
        rst = 1'b0;
        issue(32'h0000_0010, 32'h0000_0020);   wait_done(0);

        for (int i = 0; i < 30; i++) begin
            ra = pick();
            rb = ($urandom_range(0, 5) == 0) ? ra : pick();
            if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            issue(ra, rb);
            wait_done(1);
        end

        repeat (4) @(negedge clk);
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
